spram_bus_bridge: RTL and testbench
===================================

Name: spram_bus_bridge

Overview:
- Bridges the 32-bit RISC-V core data/instruction memory port to four SB_SPRAM256KA macros. The macros are organised as two 32-bit banks of 16K words each, 128 KiB total.
- Sits directly upstream of the SPRAM primitives; drives every SPRAM control pin.
- Owns power-up settling, read-data capture/hold, nibble write-mask expansion and an optional standby low-power mode.

Parameters:
- ADDR_W, 15, word-address width; bit ADDR_W-1 selects the bank, bits 13:0 index the word.
- PWRUP_CYCLES, 16, cycles after reset release before the first access is accepted (range 1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetq  in  1  asynchronous active-low reset
- mem_addr  in  ADDR_W  word address
- mem_wdata  in  32  write data
- mem_wmask  in  4  byte write enables; nonzero = write request
- mem_rstrb  in  1  one-cycle read request pulse
- mem_rdata  out  32  read data, registered
- mem_rbusy  out  1  read in progress
- mem_wbusy  out  1  write in progress
- lp_req  in  1  request standby when idle
- spram_addr  out  14  shared SPRAM ADDRESS
- spram_din  out  32  [15:0] to the low-half macros, [31:16] to the high-half macros
- spram_maskwren  out  8  [3:0] low-half MASKWREN, [7:4] high-half MASKWREN
- spram_wren  out  1  shared WREN
- spram_cs  out  2  CHIPSELECT per bank
- spram_standby  out  1  STANDBY to all macros
- spram_sleep  out  1  SLEEP to all macros, tied 0
- spram_poweroff  out  1  POWEROFF to all macros (active-low power), tied 1
- spram_dout0  in  32  {hi,lo} DATAOUT of bank 0
- spram_dout1  in  32  {hi,lo} DATAOUT of bank 1

Behaviour:
- Reset values:
  - mem_rdata 0, spram_addr 0, spram_din 0, spram_maskwren 0, spram_wren 0, spram_cs 0, spram_standby 0.
  - mem_rbusy 1 and mem_wbusy 1 (held until power-up completes).
  - spram_sleep 0 and spram_poweroff 1 permanently, so RAM contents survive resetq.
- All SPRAM-facing outputs are registered.
- Byte-to-nibble mask expansion: spram_maskwren[2k+1:2k] = {2{mem_wmask[k]}}.
- State PWRUP:
  - An 8-bit counter loads PWRUP_CYCLES-1 on reset and decrements each cycle.
  - Go to IDLE when the counter reaches 0; both busy flags clear on entering IDLE.
  - Requests presented during PWRUP are ignored.
- State IDLE, request accepted in cycle N:
  - Priority order: write (mem_wmask!=0) > read (mem_rstrb) > lp_req. On a simultaneous write and read strobe the read is dropped.
- Read:
  - Cycle N+1: spram_cs[bank]=1, wren=0, address registered; mem_rbusy=1.
  - Cycle N+2: mem_rbusy=1; mem_rdata captures spram_dout of the selected bank at the end of N+2.
  - Cycle N+3: mem_rbusy=0 and mem_rdata is valid.
  - Read latency is 3 cycles. mem_rdata holds until the next read completes; writes never disturb it.
- Write:
  - Cycle N+1: spram_cs[bank]=1, wren=1, din and maskwren driven; mem_wbusy=1.
  - Cycle N+2: cs, wren and maskwren return to 0; mem_wbusy=0, back in IDLE.
- Any request arriving while a busy flag is 1 is ignored; the bench flags it as a protocol error.
- cs is never asserted in both banks at once; it is 0 in every cycle that is not an access cycle.
- Standby:
  - lp_req in IDLE with no request: next cycle enter STBY with spram_standby=1.
  - In STBY, a read or write request, or lp_req falling, moves to WAKE. In the WAKE cycle standby=0 and busy=1.
  - A request that triggered the wake is latched and issued as though accepted in the WAKE cycle, which adds 1 cycle of latency.
  - A request that arrives during WAKE (wake was not triggered by a request) is ignored, as in any busy cycle.
- Reset asserted mid-access: the FSM goes to PWRUP and all outputs take their reset values immediately. An in-flight write may be partial; no recovery is attempted.

Test Plan:
- Power-up: release resetq, PWRUP_CYCLES=16 -> busy flags high for exactly 16 cycles. A rstrb issued at cycle 5 is ignored, with cs staying 0.
- Write/read: write 0xDEADBEEF to addr 0x0123 with wmask 4'hF, then read it back -> wbusy high 1 cycle, rbusy high 2 cycles, mem_rdata=0xDEADBEEF 3 cycles after rstrb.
- Byte mask: after the write above, write 0x00AA0000 with wmask 4'b0100, then read -> 0xDEAABEEF; spram_maskwren=8'b0011_0000 during the write cycle.
- Banking: write 0x11111111 to addr 0x0005 and 0x22222222 to addr 0x4005, then read both -> values distinct; cs=2'b01 then 2'b10 respectively.
- Standby: assert lp_req in IDLE -> standby=1 the next cycle. Then rstrb to addr 0x0123 -> standby=0, mem_rdata=0xDEAABEEF 4 cycles after rstrb.
- Simultaneous/reset: rstrb together with wmask=4'hF -> write performed, rbusy stays 0. Assert resetq low mid-read -> cs=0 and mem_rdata=0 immediately, and data written earlier is still readable afterwards.

Source files
------------

// File: rtl/spram_bus_bridge.sv
// rtl/spram_bus_bridge.sv - RISC-V memory port to dual-bank SB_SPRAM256KA bridge
module spram_bus_bridge #(
    parameter int ADDR_W       = 15,
    parameter int PWRUP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wmask,
    input  logic              mem_rstrb,
    output logic [31:0]       mem_rdata,
    output logic              mem_rbusy,
    output logic              mem_wbusy,
    input  logic              lp_req,
    output logic [13:0]       spram_addr,
    output logic [31:0]       spram_din,
    output logic [7:0]        spram_maskwren,
    output logic              spram_wren,
    output logic [1:0]        spram_cs,
    output logic              spram_standby,
    output logic              spram_sleep,
    output logic              spram_poweroff,
    input  logic [31:0]       spram_dout0,
    input  logic [31:0]       spram_dout1
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR,
        S_STBY,
        S_WAKE
    } state_t;

    state_t            state, state_d;
    logic [7:0]        pwr_cnt, pwr_cnt_d;
    logic              rd_bank, rd_bank_d;
    logic              pend_rd, pend_rd_d;
    logic [3:0]        pend_wmask, pend_wmask_d;
    logic [ADDR_W-1:0] pend_addr, pend_addr_d;
    logic [31:0]       pend_wdata, pend_wdata_d;

    logic [13:0]       addr_d;
    logic [31:0]       din_d;
    logic [7:0]        mask_d;
    logic              wren_d;
    logic [1:0]        cs_d;
    logic              standby_d;
    logic [31:0]       rdata_d;

    logic              req_wr, req_rd;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wmask;

    // Contents must survive resetq, so the macros are never put to sleep or powered off.
    assign spram_sleep    = 1'b0;
    assign spram_poweroff = 1'b1;

    // Busy while powering up, waking, or while an access is in flight.
    assign mem_rbusy = (state == S_PWRUP) || (state == S_WAKE) ||
                       (state == S_RD1) || (state == S_RD2);
    assign mem_wbusy = (state == S_PWRUP) || (state == S_WAKE) || (state == S_WR);

    // Next-state and next-output logic; a wake replays the request latched in standby.
    always_comb begin
        state_d      = state;
        pwr_cnt_d    = pwr_cnt;
        rd_bank_d    = rd_bank;
        pend_rd_d    = pend_rd;
        pend_wmask_d = pend_wmask;
        pend_addr_d  = pend_addr;
        pend_wdata_d = pend_wdata;
        addr_d       = spram_addr;
        din_d        = spram_din;
        mask_d       = 8'h00;
        wren_d       = 1'b0;
        cs_d         = 2'b00;
        standby_d    = 1'b0;
        rdata_d      = mem_rdata;

        if (state == S_WAKE) begin
            req_wr    = |pend_wmask;
            req_rd    = pend_rd;
            req_addr  = pend_addr;
            req_wdata = pend_wdata;
            req_wmask = pend_wmask;
        end else begin
            req_wr    = |mem_wmask;
            req_rd    = mem_rstrb;
            req_addr  = mem_addr;
            req_wdata = mem_wdata;
            req_wmask = mem_wmask;
        end

        case (state)
            S_PWRUP: begin
                if (pwr_cnt == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    pwr_cnt_d = pwr_cnt - 8'd1;
                end
            end
            S_IDLE, S_WAKE: begin
                pend_rd_d    = 1'b0;
                pend_wmask_d = 4'h0;
                if (req_wr) begin
                    state_d = S_WR;
                    cs_d    = req_addr[ADDR_W-1] ? 2'b10 : 2'b01;
                    wren_d  = 1'b1;
                    addr_d  = req_addr[13:0];
                    din_d   = req_wdata;
                    for (int k = 0; k < 4; k++) begin
                        mask_d[2*k +: 2] = {2{req_wmask[k]}};
                    end
                end else if (req_rd) begin
                    state_d   = S_RD1;
                    cs_d      = req_addr[ADDR_W-1] ? 2'b10 : 2'b01;
                    addr_d    = req_addr[13:0];
                    rd_bank_d = req_addr[ADDR_W-1];
                end else if ((state == S_IDLE) && lp_req) begin
                    state_d   = S_STBY;
                    standby_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD1: begin
                state_d = S_RD2;
            end
            S_RD2: begin
                rdata_d = rd_bank ? spram_dout1 : spram_dout0;
                state_d = S_IDLE;
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_STBY: begin
                standby_d = 1'b1;
                if ((|mem_wmask) || mem_rstrb || !lp_req) begin
                    state_d      = S_WAKE;
                    standby_d    = 1'b0;
                    pend_rd_d    = mem_rstrb;
                    pend_wmask_d = mem_wmask;
                    pend_addr_d  = mem_addr;
                    pend_wdata_d = mem_wdata;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase
    end

    // State, pending request and all registered outputs.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state          <= S_PWRUP;
            pwr_cnt        <= 8'(PWRUP_CYCLES - 1);
            rd_bank        <= 1'b0;
            pend_rd        <= 1'b0;
            pend_wmask     <= 4'h0;
            pend_addr      <= '0;
            pend_wdata     <= 32'h0;
            spram_addr     <= 14'h0;
            spram_din      <= 32'h0;
            spram_maskwren <= 8'h00;
            spram_wren     <= 1'b0;
            spram_cs       <= 2'b00;
            spram_standby  <= 1'b0;
            mem_rdata      <= 32'h0;
        end else begin
            state          <= state_d;
            pwr_cnt        <= pwr_cnt_d;
            rd_bank        <= rd_bank_d;
            pend_rd        <= pend_rd_d;
            pend_wmask     <= pend_wmask_d;
            pend_addr      <= pend_addr_d;
            pend_wdata     <= pend_wdata_d;
            spram_addr     <= addr_d;
            spram_din      <= din_d;
            spram_maskwren <= mask_d;
            spram_wren     <= wren_d;
            spram_cs       <= cs_d;
            spram_standby  <= standby_d;
            mem_rdata      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spram_bus_bridge.sv
// tb/tb_spram_bus_bridge.sv - scoreboard testbench for spram_bus_bridge
module tb_spram_bus_bridge;

    logic        clk = 1'b0;
    logic        resetq;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        lp_req;
    logic [13:0] spram_addr;
    logic [31:0] spram_din;
    logic [7:0]  spram_maskwren;
    logic        spram_wren;
    logic [1:0]  spram_cs;
    logic        spram_standby;
    logic        spram_sleep;
    logic        spram_poweroff;
    logic [31:0] dout0, dout1;

    always #5 clk = ~clk;

    spram_bus_bridge #(.ADDR_W(15), .PWRUP_CYCLES(16)) dut (
        .clk(clk), .resetq(resetq),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .lp_req(lp_req),
        .spram_addr(spram_addr), .spram_din(spram_din),
        .spram_maskwren(spram_maskwren), .spram_wren(spram_wren),
        .spram_cs(spram_cs), .spram_standby(spram_standby),
        .spram_sleep(spram_sleep), .spram_poweroff(spram_poweroff),
        .spram_dout0(dout0), .spram_dout1(dout1)
    );

    // Behavioural SPRAM banks: synchronous read, nibble-masked write.
    logic [31:0] ram0 [16384];
    logic [31:0] ram1 [16384];
    logic [31:0] wtmp;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram0[i] = 32'h0;
            ram1[i] = 32'h0;
        end
        dout0 = 32'h0;
        dout1 = 32'h0;
    end

    always @(posedge clk) begin
        if (!spram_standby && spram_cs[0]) begin
            if (spram_wren) begin
                wtmp = ram0[spram_addr];
                for (int n = 0; n < 8; n++)
                    if (spram_maskwren[n]) wtmp[4*n +: 4] = spram_din[4*n +: 4];
                ram0[spram_addr] = wtmp;
            end else begin
                dout0 <= ram0[spram_addr];
            end
        end
        if (!spram_standby && spram_cs[1]) begin
            if (spram_wren) begin
                wtmp = ram1[spram_addr];
                for (int n = 0; n < 8; n++)
                    if (spram_maskwren[n]) wtmp[4*n +: 4] = spram_din[4*n +: 4];
                ram1[spram_addr] = wtmp;
            end else begin
                dout1 <= ram1[spram_addr];
            end
        end
    end

    typedef struct { logic [1:0] cs; logic [13:0] addr; logic [31:0] din; logic [7:0] mask; } wr_t;
    typedef struct { logic [1:0] cs; logic [13:0] addr; } acc_t;
    typedef struct { logic [31:0] data; int issue; int lat; } rd_t;

    wr_t  wq [$];
    acc_t aq [$];
    rd_t  rq [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic prev_rbusy = 1'b1;
    wr_t  mw;
    acc_t ma;
    rd_t  mr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT drives an access or completes a read.
    always @(negedge clk) begin
        if (mon_en) begin
            if (spram_cs == 2'b11) bad("cs_both_banks");
            if (spram_standby && spram_cs != 2'b00) bad("cs_in_standby");
            if (spram_cs != 2'b00 && spram_wren) begin
                if (wq.size() == 0) bad("unexpected_write");
                else begin
                    mw = wq.pop_front();
                    chk("wr_cs", {30'h0, spram_cs}, {30'h0, mw.cs});
                    chk("wr_addr", {18'h0, spram_addr}, {18'h0, mw.addr});
                    chk("wr_din", spram_din, mw.din);
                    chk("wr_maskwren", {24'h0, spram_maskwren}, {24'h0, mw.mask});
                end
            end else if (spram_cs != 2'b00) begin
                if (aq.size() == 0) bad("unexpected_read_access");
                else begin
                    ma = aq.pop_front();
                    chk("rd_cs", {30'h0, spram_cs}, {30'h0, ma.cs});
                    chk("rd_addr", {18'h0, spram_addr}, {18'h0, ma.addr});
                end
            end
            if (prev_rbusy && !mem_rbusy) begin
                if (rq.size() == 0) bad("unexpected_read_done");
                else begin
                    mr = rq.pop_front();
                    chk("rd_data", mem_rdata, mr.data);
                    chk("rd_latency", cyc - mr.issue, mr.lat);
                end
            end
        end
        prev_rbusy <= mem_rbusy;
    end

    task automatic power_up();
        int busy_n = 0;
        int cs_n = 0;
        resetq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!(mem_rbusy && mem_wbusy)) break;
            busy_n++;
            if (spram_cs != 2'b00) cs_n++;
            mem_addr  = 15'h0123;
            mem_rstrb = (i == 5);
            @(negedge clk);
        end
        mem_rstrb = 1'b0;
        chk("pwrup_busy_cycles", busy_n, 16);
        chk("pwrup_cs_quiet", cs_n, 0);
        chk("pwrup_rbusy_clear", {31'h0, mem_rbusy}, 32'h0);
        chk("pwrup_wbusy_clear", {31'h0, mem_wbusy}, 32'h0);
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic wait_rd();
        int n;
        for (n = 0; n < 12 && mem_rbusy; n++) @(negedge clk);
        if (n == 12) bad("read_timeout");
        @(posedge clk); #1;
    endtask

    task automatic expect_read(input logic [14:0] a, input logic [31:0] d, input int lat);
        acc_t ea;
        rd_t  er;
        ea.cs = a[14] ? 2'b10 : 2'b01;
        ea.addr = a[13:0];
        er.data = d;
        er.issue = cyc;
        er.lat = lat;
        aq.push_back(ea);
        rq.push_back(er);
    endtask

    task automatic do_read(input logic [14:0] a, input logic [31:0] d);
        expect_read(a, d, 3);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        wait_rd();
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] m,
                            input logic [7:0] exp_mask, input logic with_rd);
        wr_t ew;
        ew.cs = a[14] ? 2'b10 : 2'b01;
        ew.addr = a[13:0];
        ew.din = d;
        ew.mask = exp_mask;
        wq.push_back(ew);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = with_rd;
        @(posedge clk); #1;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        @(negedge clk);
        chk("wbusy_access", {31'h0, mem_wbusy}, 32'h1);
        chk("rbusy_during_write", {31'h0, mem_rbusy}, 32'h0);
        @(negedge clk);
        chk("wbusy_after", {31'h0, mem_wbusy}, 32'h0);
        chk("rbusy_after_write", {31'h0, mem_rbusy}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetq    = 1'b0;
        mem_addr  = 15'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        lp_req    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_addr", {18'h0, spram_addr}, 32'h0);
        chk("rst_din", spram_din, 32'h0);
        chk("rst_maskwren", {24'h0, spram_maskwren}, 32'h0);
        chk("rst_wren", {31'h0, spram_wren}, 32'h0);
        chk("rst_cs", {30'h0, spram_cs}, 32'h0);
        chk("rst_standby", {31'h0, spram_standby}, 32'h0);
        chk("rst_rbusy", {31'h0, mem_rbusy}, 32'h1);
        chk("rst_wbusy", {31'h0, mem_wbusy}, 32'h1);
        chk("rst_sleep", {31'h0, spram_sleep}, 32'h0);
        chk("rst_poweroff", {31'h0, spram_poweroff}, 32'h1);

        power_up();

        do_write(15'h0123, 32'hDEADBEEF, 4'hF, 8'hFF, 1'b0);
        do_read(15'h0123, 32'hDEADBEEF);
        do_write(15'h0123, 32'h00AA0000, 4'b0100, 8'b0011_0000, 1'b0);
        do_read(15'h0123, 32'hDEAABEEF);

        do_write(15'h0005, 32'h11111111, 4'hF, 8'hFF, 1'b0);
        do_write(15'h4005, 32'h22222222, 4'hF, 8'hFF, 1'b0);
        do_read(15'h0005, 32'h11111111);
        do_read(15'h4005, 32'h22222222);

        lp_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stby_entered", {31'h0, spram_standby}, 32'h1);
        chk("stby_rbusy", {31'h0, mem_rbusy}, 32'h0);
        @(posedge clk); #1;
        chk("stby_held", {31'h0, spram_standby}, 32'h1);
        expect_read(15'h0123, 32'hDEAABEEF, 4);
        mem_addr  = 15'h0123;
        mem_rstrb = 1'b1;
        lp_req    = 1'b0;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        @(negedge clk);
        chk("wake_standby", {31'h0, spram_standby}, 32'h0);
        chk("wake_rbusy", {31'h0, mem_rbusy}, 32'h1);
        chk("wake_cs", {30'h0, spram_cs}, 32'h0);
        wait_rd();

        do_write(15'h0200, 32'h5A5A5A5A, 4'hF, 8'hFF, 1'b1);

        do_read(15'h0005, 32'h11111111);
        expect_read(15'h4005, 32'h0, 3);
        mem_addr  = 15'h4005;
        mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        @(negedge clk); #1;
        resetq = 1'b0;
        mon_en = 1'b0;
        rq.delete();
        #1;
        chk("midrst_cs", {30'h0, spram_cs}, 32'h0);
        chk("midrst_rdata", mem_rdata, 32'h0);
        chk("midrst_rbusy", {31'h0, mem_rbusy}, 32'h1);
        repeat (2) @(negedge clk);
        power_up();

        do_read(15'h0005, 32'h11111111);
        do_read(15'h0200, 32'h5A5A5A5A);
        do_read(15'h0123, 32'hDEAABEEF);
        do_read(15'h4005, 32'h22222222);

        repeat (2) @(negedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("aq_drained", aq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
